ram_stream_loader: RTL and testbench

- Writer-side counterpart to the team's 256x8 lookup ROM.
- Holds a 256x8 on-chip RAM and fills it from a byte stream using a valid/ready handshake.
- Writes go to consecutive addresses starting at a programmable base. The address wraps at the top of the array.
- A registered random-access read port lets downstream logic consume the loaded table, so the block can stand in for the ROM once loaded.

---
 rtl/ram_stream_loader.sv | 145 ++++++++++++++
 tb/tb_ram_stream_loader.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_loader.sv
// Streams words from a valid/ready source into a 256x8 RAM at consecutive (wrapping) addresses,
// with a registered read port. Optional running checksum output: RAM_STREAM_LOADER_CHECKSUM_EN.
module ram_stream_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] checksum
`else
    output logic [DATA_WIDTH-1:0] rd_data
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;
    logic [ADDR_WIDTH:0]     remaining_reg, remaining_next;
    logic [ADDR_WIDTH:0]     count_reg, count_next;
    logic [DATA_WIDTH-1:0]   rd_data_reg;
    logic                    wr_en;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   checksum_reg, checksum_next;
`endif

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        count_next     = count_reg;
        wr_en          = 1'b0;
        in_ready       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        checksum_next  = checksum_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    count_next = '0;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
                    checksum_next = '0;
`endif
                    if (length == '0) begin
                        state_next = S_DONE;
                    end else begin
                        ptr_next       = start_addr;
                        remaining_next = (length > LEN_MAX) ? LEN_MAX : length;
                        state_next     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    wr_en          = 1'b1;
                    ptr_next       = ptr_reg + ADDR_WIDTH'(1);
                    remaining_next = remaining_reg - LEN_ONE;
                    count_next     = count_reg + LEN_ONE;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
                    checksum_next  = checksum_reg + in_data;
`endif
                    if (remaining_reg == LEN_ONE) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            count_reg     <= '0;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
            checksum_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            remaining_reg <= remaining_next;
            count_reg     <= count_next;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
            checksum_reg  <= checksum_next;
`endif
        end
    end

    // RAM contents survive reset; the write is suppressed on a reset edge so an abort is immediate.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[ptr_reg] <= in_data;
        end
    end

    // Read-before-write: the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data  = rd_data_reg;
    assign wr_count = count_reg;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed bench for ram_stream_loader; inputs driven and outputs sampled on the falling edge.
module tb_ram_stream_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] start_addr = '0;
    logic [8:0] length = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [8:0] wr_count;
    logic [7:0] rd_addr = '0;
    logic [7:0] rd_data;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_stream_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .length(length),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .busy(busy),
        .done(done),
        .wr_count(wr_count),
        .rd_addr(rd_addr),
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        .rd_data(rd_data),
        .checksum(checksum)
`else
        .rd_data(rd_data)
`endif
    );

    // Drives a load with in_valid held high and data base, base+1, ...; stops at the done pulse.
    task automatic run_load(input logic [7:0] addr, input logic [8:0] len, input logic [7:0] base,
                            input int budget, output int accepted, output int cycles, output bit seen_done);
        bit will;
        accepted = 0;
        cycles = 0;
        seen_done = 1'b0;
        start = 1'b1;
        start_addr = addr;
        length = len;
        @(negedge clk);
        start = 1'b0;
        while (cycles < budget) begin
            if (done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            in_valid = 1'b1;
            in_data = base + 8'(accepted);
            will = (in_ready === 1'b1);
            @(negedge clk);
            cycles++;
            if (will) accepted++;
        end
        in_valid = 1'b0;
    endtask

    task automatic read_mem(input logic [7:0] addr, output logic [7:0] data);
        rd_addr = addr;
        @(negedge clk);
        data = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got ready/busy/done=%b expected 000", {in_ready, busy, done});
        end
        checks++;
        if (wr_count !== 9'd0) begin
            errors++;
            $display("FAIL reset_wr_count: got %0d expected 0", wr_count);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] d [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        logic [7:0] v;
        start = 1'b1;
        start_addr = 8'h10;
        length = 9'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_in_ready word %0d: got %b expected 1", i, in_ready);
            end
            in_valid = 1'b1;
            in_data = d[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b ready=%b expected 1 0", done, in_ready);
        end
        checks++;
        if (wr_count !== 9'd4) begin
            errors++;
            $display("FAIL basic_wr_count: got %0d expected 4", wr_count);
        end
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        // A1+B2+C3+D4 = 0x2EA, truncated to 8 bits
        checks++;
        if (checksum !== 8'hEA) begin
            errors++;
            $display("FAIL basic_checksum: got %h expected EA", checksum);
        end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            read_mem(8'h10 + 8'(i), v);
            checks++;
            if (v !== d[i]) begin
                errors++;
                $display("FAIL basic_read addr %h: got %h expected %h", 8'h10 + 8'(i), v, d[i]);
            end
        end
        $display("test_basic done");
    endtask

    task automatic test_stall();
        logic [7:0] d [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] v;
        start = 1'b1;
        start_addr = 8'h20;
        length = 9'd3;
        @(negedge clk);
        start = 1'b0;
        // cycles 1..8: word0, five idle cycles, word1, word2; done expected at cycle 9
        for (int n = 1; n <= 8; n++) begin
            in_valid = (n == 1 || n >= 7);
            in_data = (n == 1) ? d[0] : (n == 7) ? d[1] : (n == 8) ? d[2] : 8'hEE;
            if (n >= 2 && n <= 6) begin
                checks++;
                if (wr_count !== 9'd1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_gap cycle %0d: got count=%0d done=%b expected 1 0", n, wr_count, done);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || wr_count !== 9'd3) begin
            errors++;
            $display("FAIL stall_done: got done=%b count=%0d expected 1 3", done, wr_count);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            read_mem(8'h20 + 8'(i), v);
            checks++;
            if (v !== d[i]) begin
                errors++;
                $display("FAIL stall_read addr %h: got %h expected %h", 8'h20 + 8'(i), v, d[i]);
            end
        end
        $display("test_stall done");
    endtask

    task automatic test_wrap();
        int acc, cyc;
        bit ok;
        logic [7:0] v;
        logic [7:0] addrs [6] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        logic [7:0] exp   [6] = '{8'h51, 8'h01, 8'h02, 8'h03, 8'h04, 8'h56};
        run_load(8'hFC, 9'd8, 8'h50, 50, acc, cyc, ok);
        @(negedge clk);
        run_load(8'hFE, 9'd4, 8'h01, 50, acc, cyc, ok);
        checks++;
        if (!ok || wr_count !== 9'd4) begin
            errors++;
            $display("FAIL wrap_done: got done_seen=%b count=%0d expected 1 4", ok, wr_count);
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            read_mem(addrs[i], v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL wrap_read addr %h: got %h expected %h", addrs[i], v, exp[i]);
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_clamp();
        int acc, cyc;
        bit ok;
        logic [7:0] v;
        run_load(8'h00, 9'd300, 8'h00, 400, acc, cyc, ok);
        checks++;
        if (!ok || acc != 256 || cyc != 256) begin
            errors++;
            $display("FAIL clamp_accepted: got done_seen=%b words=%0d cycles=%0d expected 1 256 256", ok, acc, cyc);
        end
        checks++;
        if (wr_count !== 9'd256) begin
            errors++;
            $display("FAIL clamp_wr_count: got %0d expected 256", wr_count);
        end
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        // sum 0..255 = 0x7F80
        checks++;
        if (checksum !== 8'h80) begin
            errors++;
            $display("FAIL clamp_checksum: got %h expected 80", checksum);
        end
`endif
        @(negedge clk);
        read_mem(8'hFF, v);
        checks++;
        if (v !== 8'hFF) begin
            errors++;
            $display("FAIL clamp_read addr ff: got %h expected ff", v);
        end
        read_mem(8'h10, v);
        checks++;
        if (v !== 8'h10) begin
            errors++;
            $display("FAIL clamp_read addr 10: got %h expected 10", v);
        end
        $display("test_clamp done");
    endtask

    task automatic test_zero_length();
        logic [7:0] v;
        start = 1'b1;
        start_addr = 8'h40;
        length = 9'd0;
        in_valid = 1'b1;
        in_data = 8'h99;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0 || wr_count !== 9'd0) begin
            errors++;
            $display("FAIL zero_done: got done=%b ready=%b count=%0d expected 1 0 0", done, in_ready, wr_count);
        end
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 8'h00) begin
            errors++;
            $display("FAIL zero_checksum: got %h expected 00", checksum);
        end
`endif
        @(negedge clk);
        in_valid = 1'b0;
        read_mem(8'h40, v);
        checks++;
        if (v !== 8'h40 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_write: got mem=%h done=%b expected 40 0", v, done);
        end
        $display("test_zero_length done");
    endtask

    task automatic test_read_during_write();
        start = 1'b1;
        start_addr = 8'h80;
        length = 9'd1;
        rd_addr = 8'h80;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (rd_data !== 8'h80) begin
            errors++;
            $display("FAIL rbw_old: got %h expected 80", rd_data);
        end
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL rbw_new: got %h expected 3c", rd_data);
        end
        $display("test_read_during_write done");
    endtask

    task automatic test_abort();
        int acc, cyc;
        bit ok;
        bit saw_done;
        logic [7:0] v;
        logic [7:0] addrs [4] = '{8'h60, 8'h61, 8'h62, 8'h71};
        logic [7:0] exp   [4] = '{8'hC1, 8'hC2, 8'h62, 8'h71};
        start = 1'b1;
        start_addr = 8'h60;
        length = 9'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = 8'hC1 + 8'(i);
            @(negedge clk);
        end
        in_data = 8'hC3;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, done} !== 3'b000 || wr_count !== 9'd0) begin
            errors++;
            $display("FAIL abort_state: got ready/busy/done=%b count=%0d expected 000 0", {in_ready, busy, done}, wr_count);
        end
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_quiet: got done/busy activity after abort expected none");
        end
        run_load(8'h70, 9'd1, 8'h5A, 20, acc, cyc, ok);
        start = 1'b1;
        start_addr = 8'h71;
        length = 9'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_start_ignored: got busy=%b ready=%b expected 0 0", busy, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            read_mem(addrs[i], v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL abort_read addr %h: got %h expected %h", addrs[i], v, exp[i]);
            end
        end
        $display("test_abort done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_clamp();
        test_zero_length();
        test_read_during_write();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
